// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/DMA data-memory arbiter with starvation guard and registered one-access-per-3-cycles handshake.
// Optional DMEM_ARB_MISALIGN_CHECK_EN adds cpu_err/dma_err and blocks unaligned accesses.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ready,
  output logic [31:0] dma_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  ,
  output logic        cpu_err,
  output logic        dma_err
`endif
);
  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic owner_q, owner_d;
  logic bad_q, bad_d;
  logic mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic cpu_ready_q, cpu_ready_d, dma_ready_q, dma_ready_d;
  logic cpu_err_q, cpu_err_d, dma_err_q, dma_err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, resp_q, resp_d;
  logic dma_win, gnt_we, gnt_bad;
  logic [31:0] gnt_addr, gnt_wdata;
  assign dma_win   = dma_req && (!cpu_req || starve_q >= 4'(STARVE_LIMIT));
  assign gnt_we    = dma_win ? dma_we : cpu_we;
  assign gnt_addr  = dma_win ? dma_addr : cpu_addr;
  assign gnt_wdata = dma_win ? dma_wdata : cpu_wdata;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  assign gnt_bad = gnt_addr[1:0] != 2'b00;
  assign cpu_err = cpu_err_q;
  assign dma_err = dma_err_q;
`else
  assign gnt_bad = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    bad_d       = bad_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_d      = resp_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    cpu_err_d   = 1'b0;
    dma_err_d   = 1'b0;
    case (state_q)
      IDLE: if (cpu_req || dma_req) begin
        state_d     = ACC;
        owner_d     = dma_win;
        bad_d       = gnt_bad;
        addr_d      = gnt_addr;
        wdata_d     = gnt_wdata;
        mem_read_d  = !gnt_we && !gnt_bad;
        mem_write_d = gnt_we && !gnt_bad;
        starve_d    = dma_win ? 4'd0 : (dma_req && starve_q != 4'd15) ? starve_q + 4'd1 : starve_q;
      end
      ACC: begin
        state_d     = RESP;
        resp_d      = bad_q ? 32'd0 : mem_rdata;
        cpu_ready_d = !owner_q;
        dma_ready_d = owner_q;
        cpu_err_d   = bad_q && !owner_q;
        dma_err_d   = bad_q && owner_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // Async reset clears the enables at once so an in-flight access never commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      owner_q     <= 1'b0;
      bad_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      dma_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      bad_q       <= bad_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_q      <= resp_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
      cpu_err_q   <= cpu_err_d;
      dma_err_q   <= dma_err_d;
    end
  end
  assign cpu_ready = cpu_ready_q;
  assign dma_ready = dma_ready_q;
  assign cpu_rdata = resp_q;
  assign dma_rdata = resp_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed checks of dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;
  localparam int NRAND = 600;
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic cpu_ready, dma_ready, mem_read, mem_write;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  logic cpu_err, dma_err;
`endif
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int checks = 0, passed = 0;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    , .cpu_err(cpu_err), .dma_err(dma_err)
`endif
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    cpu_req = 0; dma_req = 0; cpu_we = 0; dma_we = 0;
    rst = 1;
    step;
    step;
    rst = 0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({mem_read, mem_write, cpu_ready, dma_ready} !== 4'b0 || mem_addr !== 0 || mem_wdata !== 0 || cpu_rdata !== 0 || dma_rdata !== 0)
      $display("FAIL reset_outputs: got rd=%b wr=%b cr=%b dr=%b addr=%h want all 0", mem_read, mem_write, cpu_ready, dma_ready, mem_addr);
    else passed++;
    step;
    step;
    checks++;
    if ({mem_read, mem_write, cpu_ready, dma_ready} !== 4'b0)
      $display("FAIL idle_no_req: got %b want 0000", {mem_read, mem_write, cpu_ready, dma_ready});
    else passed++;
  endtask

  task automatic test_cpu_load;
    mem[4] = 32'hDEADBEEF;
    do_reset;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    step;
    checks++;
    if (mem_read !== 1 || mem_write !== 0 || mem_addr !== 32'h10 || cpu_ready !== 0)
      $display("FAIL load_acc: got rd=%b wr=%b addr=%h rdy=%b want 1 0 00000010 0", mem_read, mem_write, mem_addr, cpu_ready);
    else passed++;
    step;
    checks++;
    if (cpu_ready !== 1 || cpu_rdata !== 32'hDEADBEEF || dma_ready !== 0 || mem_read !== 0)
      $display("FAIL load_resp: got rdy=%b data=%h dma_rdy=%b rd=%b want 1 deadbeef 0 0", cpu_ready, cpu_rdata, dma_ready, mem_read);
    else passed++;
    cpu_req = 0;
    step;
    checks++;
    if (cpu_ready !== 0)
      $display("FAIL ready_one_cycle: got %b want 0", cpu_ready);
    else passed++;
  endtask

  task automatic test_fairness;
    logic [9:0] got, exp;
    int n, cnt;
    do_reset;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    dma_req = 1; dma_we = 0; dma_addr = 32'h200;
    n = 0;
    got = '0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      step;
      if (cpu_ready || dma_ready) begin
        got[n] = dma_ready;
        n++;
      end
    end
    cpu_req = 0; dma_req = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      exp[i] = cnt >= LIMIT;
      cnt = exp[i] ? 0 : cnt + 1;
    end
    checks++;
    if (n != 10) $display("FAIL fair_count: got %0d grants want 10", n);
    else passed++;
    checks++;
    if (got !== exp) $display("FAIL fair_order: got %b want %b (bit0 first, 1=DMA)", got, exp);
    else passed++;
    step;
    step;
  endtask

  task automatic test_dma_store_cpu_load;
    int seen;
    do_reset;
    dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h12345678;
    step;
    checks++;
    if (mem_write !== 1 || mem_read !== 0 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678)
      $display("FAIL dma_store_acc: got wr=%b rd=%b addr=%h data=%h want 1 0 00000040 12345678", mem_write, mem_read, mem_addr, mem_wdata);
    else passed++;
    step;
    checks++;
    if (dma_ready !== 1 || cpu_ready !== 0 || mem_write !== 0)
      $display("FAIL dma_store_resp: got dma_rdy=%b cpu_rdy=%b wr=%b want 1 0 0", dma_ready, cpu_ready, mem_write);
    else passed++;
    dma_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step;
      if (cpu_ready) seen = 1;
    end
    cpu_req = 0;
    checks++;
    if (seen != 1 || cpu_rdata !== 32'h12345678)
      $display("FAIL readback: got seen=%0d data=%h want 1 12345678", seen, cpu_rdata);
    else passed++;
    step;
  endtask

  task automatic test_reset_mid_access;
    int rdy;
    mem[32] = 32'hA5A5A5A5;
    do_reset;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'h11111111;
    step;
    checks++;
    if (mem_write !== 1) $display("FAIL mid_acc_write: got %b want 1", mem_write);
    else passed++;
    rst = 1;
    cpu_req = 0;
    #1;
    checks++;
    if (mem_write !== 0 || cpu_ready !== 0)
      $display("FAIL mid_rst_drop: got wr=%b rdy=%b want 0 0", mem_write, cpu_ready);
    else passed++;
    rdy = 0;
    step;
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      step;
      rdy |= int'(cpu_ready | dma_ready);
    end
    checks++;
    if (mem[32] !== 32'hA5A5A5A5 || rdy != 0)
      $display("FAIL mid_rst_mem: got mem=%h ready_seen=%0d want a5a5a5a5 0", mem[32], rdy);
    else passed++;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
    step;
    step;
    cpu_req = 0;
    checks++;
    if (cpu_ready !== 1 || cpu_rdata !== 32'hA5A5A5A5)
      $display("FAIL post_rst_load: got rdy=%b data=%h want 1 a5a5a5a5", cpu_ready, cpu_rdata);
    else passed++;
    step;
  endtask

  task automatic test_misalign;
    mem[16] = 32'h0;
    do_reset;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h41; cpu_wdata = 32'hCAFEF00D;
    step;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    checks++;
    if (mem_write !== 0 || mem_read !== 0)
      $display("FAIL misalign_acc: got wr=%b rd=%b want 0 0", mem_write, mem_read);
    else passed++;
    step;
    checks++;
    if (cpu_ready !== 1 || cpu_err !== 1 || cpu_rdata !== 0 || dma_err !== 0)
      $display("FAIL misalign_resp: got rdy=%b err=%b data=%h derr=%b want 1 1 0 0", cpu_ready, cpu_err, cpu_rdata, dma_err);
    else passed++;
    cpu_req = 0;
    step;
    checks++;
    if (mem[16] !== 32'h0) $display("FAIL misalign_mem: got %h want 0", mem[16]);
    else passed++;
`else
    checks++;
    if (mem_write !== 1 || mem_addr !== 32'h41)
      $display("FAIL unaligned_pass: got wr=%b addr=%h want 1 00000041", mem_write, mem_addr);
    else passed++;
    step;
    checks++;
    if (cpu_ready !== 1) $display("FAIL unaligned_ready: got %b want 1", cpu_ready);
    else passed++;
    cpu_req = 0;
    step;
    checks++;
    if (mem[16] !== 32'hCAFEF00D) $display("FAIL unaligned_mem: got %h want cafef00d", mem[16]);
    else passed++;
`endif
  endtask

  task automatic test_drop_req;
    mem[12] = 32'h0BADF00D;
    mem[20] = 32'h5EEDFACE;
    do_reset;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
    dma_req = 1; dma_we = 0; dma_addr = 32'h50;
    step;
    cpu_req = 0;
    checks++;
    if (mem_read !== 1 || mem_addr !== 32'h30)
      $display("FAIL drop_acc: got rd=%b addr=%h want 1 00000030", mem_read, mem_addr);
    else passed++;
    step;
    checks++;
    if (cpu_ready !== 1 || dma_ready !== 0 || cpu_rdata !== 32'h0BADF00D)
      $display("FAIL drop_ready: got rdy=%b drdy=%b data=%h want 1 0 0badf00d", cpu_ready, dma_ready, cpu_rdata);
    else passed++;
    step;
    step;
    checks++;
    if (mem_read !== 1 || mem_addr !== 32'h50)
      $display("FAIL drop_dma_grant: got rd=%b addr=%h want 1 00000050", mem_read, mem_addr);
    else passed++;
    step;
    dma_req = 0;
    checks++;
    if (dma_ready !== 1 || cpu_ready !== 0 || dma_rdata !== 32'h5EEDFACE)
      $display("FAIL drop_dma_ready: got drdy=%b crdy=%b data=%h want 1 0 5eedface", dma_ready, cpu_ready, dma_rdata);
    else passed++;
    step;
  endtask

  task automatic test_random;
    bit hc [NRAND];
    bit hd [NRAND];
    bit ca, da, cw, dw, exp_dma;
    logic [31:0] ca_addr, da_addr, cwd, dwd;
    int cnt, errs;
    do_reset;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    ca = 0; da = 0; cw = 0; dw = 0; cnt = 0;
    ca_addr = 0; da_addr = 0; cwd = 0; dwd = 0;
    for (int k = 0; k < NRAND; k++) begin
      if (cpu_ready || dma_ready) begin
        errs = 0;
        if (k < 2 || (cpu_ready && dma_ready) || (cpu_ready && !ca) || (dma_ready && !da)) errs = 1;
        else begin
          exp_dma = hd[k-2] && (!hc[k-2] || cnt >= LIMIT);
          if (exp_dma != dma_ready) errs = 2;
          cnt = exp_dma ? 0 : (hd[k-2] && cnt < 15) ? cnt + 1 : cnt;
          if (dma_ready) begin
            if (!dw && dma_rdata !== ref_mem[da_addr[9:2]]) errs = 3;
            if (dw) ref_mem[da_addr[9:2]] = dwd;
            da = 0;
          end else begin
            if (!cw && cpu_rdata !== ref_mem[ca_addr[9:2]]) errs = 3;
            if (cw) ref_mem[ca_addr[9:2]] = cwd;
            ca = 0;
          end
        end
        checks++;
        if (errs != 0)
          $display("FAIL rand_txn k=%0d: got code %0d crdy=%b drdy=%b cdata=%h ddata=%h want code 0", k, errs, cpu_ready, dma_ready, cpu_rdata, dma_rdata);
        else passed++;
      end
      if (!ca && k < NRAND - 12 && $urandom_range(1) == 1) begin
        ca = 1; cw = 1'($urandom_range(1)); ca_addr = {22'd0, 8'($urandom), 2'b00}; cwd = $urandom;
      end
      if (!da && k < NRAND - 12 && $urandom_range(2) != 0) begin
        da = 1; dw = 1'($urandom_range(1)); da_addr = {22'd0, 8'($urandom), 2'b00}; dwd = $urandom;
      end
      cpu_req = ca; cpu_we = cw; cpu_addr = ca_addr; cpu_wdata = cwd;
      dma_req = da; dma_we = dw; dma_addr = da_addr; dma_wdata = dwd;
      hc[k] = ca;
      hd[k] = da;
      step;
    end
    checks++;
    if (ca || da) $display("FAIL rand_drain: got pending cpu=%b dma=%b want 0 0", ca, da);
    else passed++;
    errs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) errs++;
    checks++;
    if (errs != 0) $display("FAIL rand_mem: got %0d differing words want 0", errs);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset;
    test_cpu_load;
    test_fairness;
    test_dma_store_cpu_load;
    test_reset_mid_access;
    test_misalign;
    test_drop_req;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
